// File: rtl/lru_if.sv
// lru_if: lookup-result request bus (master drives req_*, valid_bits, flush) and way-selection response (slave drives sel_*)
interface lru_if #(
    parameter int IDX_W = 4
);
    logic             req_valid;
    logic [IDX_W-1:0] req_index;
    logic             req_hit;
    logic [1:0]       hit_way;
    logic [3:0]       valid_bits;
    logic             flush;
    logic [1:0]       sel_way;
    logic             sel_valid;
    logic             sel_hit;
    modport master (
        output req_valid, req_index, req_hit, hit_way, valid_bits, flush,
        input  sel_way, sel_valid, sel_hit
    );
    modport slave (
        input  req_valid, req_index, req_hit, hit_way, valid_bits, flush,
        output sel_way, sel_valid, sel_hit
    );
endinterface

// File: rtl/lru_way_select.sv
// lru_way_select: 4-way tree-PLRU way selector; clk/reset plain ports, requests and registered selection on lru_if slave modport
module lru_way_select #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input logic   clk,
    input logic   reset,
    lru_if.slave  bus
);
    logic [2:0] plru_q [SETS];
    logic [2:0] plru_d [SETS];
    logic [1:0] sel_way_q, sel_way_d;
    logic       sel_valid_q, sel_valid_d;
    logic       sel_hit_q, sel_hit_d;
    logic       in_range, accept;
    logic [2:0] cur;
    logic [1:0] victim, free_way, chosen;
    assign in_range = {1'b0, bus.req_index} < (IDX_W+1)'(SETS);
    assign accept   = bus.req_valid & ~bus.flush;
    assign cur      = in_range ? plru_q[bus.req_index] : 3'b000;
    assign victim   = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
    assign free_way = !bus.valid_bits[0] ? 2'd0 : !bus.valid_bits[1] ? 2'd1 : !bus.valid_bits[2] ? 2'd2 : 2'd3;
    assign chosen   = bus.req_hit ? bus.hit_way : (bus.valid_bits != 4'b1111) ? free_way : victim;
    always_comb begin
        plru_d      = plru_q;
        sel_way_d   = accept ? chosen : sel_way_q;
        sel_hit_d   = accept ? bus.req_hit : sel_hit_q;
        sel_valid_d = accept;
        if (bus.flush)
            for (int i = 0; i < SETS; i++) plru_d[i] = 3'b000;
        else if (bus.req_valid && in_range)
            plru_d[bus.req_index] = chosen[1] ? {~chosen[0], cur[1], 1'b0} : {cur[2], ~chosen[0], 1'b1};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            plru_q      <= '{default: 3'b000};
            sel_way_q   <= 2'b00;
            sel_valid_q <= 1'b0;
            sel_hit_q   <= 1'b0;
        end else begin
            plru_q      <= plru_d;
            sel_way_q   <= sel_way_d;
            sel_valid_q <= sel_valid_d;
            sel_hit_q   <= sel_hit_d;
        end
    end
    assign bus.sel_way   = sel_way_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.sel_hit   = sel_hit_q;
endmodule

// File: tb/tb_lru_way_select.sv
// tb_lru_way_select: random and directed stimulus checked every cycle against a tree-PLRU reference model
module tb_lru_way_select;
    logic clk = 0;
    logic reset = 1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   model_ok = 0;
    int   b0 [16], b1 [16], b2 [16];
    int   ew = 0, ev = 0, eh = 0;
    lru_if #(.IDX_W(4)) bus();
    lru_way_select #(.SETS(16), .IDX_W(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        int c, idx;
        idx = int'(bus.req_index);
        if (reset) begin
            for (int s = 0; s < 16; s++) begin b0[s] = 0; b1[s] = 0; b2[s] = 0; end
            ew = 0; ev = 0; eh = 0; model_ok = 1;
        end else if (bus.flush) begin
            for (int s = 0; s < 16; s++) begin b0[s] = 0; b1[s] = 0; b2[s] = 0; end
            ev = 0;
        end else if (bus.req_valid) begin
            if (bus.req_hit) c = int'(bus.hit_way);
            else if (bus.valid_bits != 4'b1111) begin
                c = -1;
                for (int w = 3; w >= 0; w--) if (!bus.valid_bits[w]) c = w;
            end else c = b0[idx] ? 2 + b2[idx] : b1[idx];
            if (c < 2) begin b0[idx] = 1; b1[idx] = (c == 0); end
            else begin b0[idx] = 0; b2[idx] = (c == 2); end
            ew = c; ev = 1; eh = int'(bus.req_hit);
        end else ev = 0;
    end
    task automatic chk(string n, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", n, $time, act, exp);
        end
    endtask
    always @(negedge clk) if (model_ok) begin
        chk("model sel_valid", int'(bus.sel_valid), ev);
        chk("model sel_way", int'(bus.sel_way), ew);
        chk("model sel_hit", int'(bus.sel_hit), eh);
    end
    task automatic lit(string n, int w, int v, int h);
        chk({n, " way"}, int'(bus.sel_way), w);
        chk({n, " valid"}, int'(bus.sel_valid), v);
        chk({n, " hit"}, int'(bus.sel_hit), h);
    endtask
    task automatic cyc(bit r, bit v, int idx, bit h, int hw, int vb, bit f);
        reset = r;
        bus.req_valid = v;
        bus.req_index = 4'(idx);
        bus.req_hit = h;
        bus.hit_way = 2'(hw);
        bus.valid_bits = 4'(vb);
        bus.flush = f;
        @(negedge clk);
    endtask
    task automatic miss(int idx, int vb);
        cyc(0, 1, idx, 0, 0, vb, 0);
    endtask
    initial begin
        int seq [5] = '{0, 2, 1, 3, 0};
        cyc(1, 1, 5, 1, 3, 15, 0);
        lit("reset", 0, 0, 0);
        foreach (seq[i]) begin
            miss(5, 15);
            lit($sformatf("set5 miss%0d", i), seq[i], 1, 0);
        end
        cyc(0, 0, 5, 1, 2, 15, 0);
        lit("idle hold", 0, 0, 0);
        miss(2, 4'b1011);
        lit("set2 invalid way", 2, 1, 0);
        miss(2, 15);
        lit("set2 plru", 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 15, 0);
        cyc(0, 1, 1, 1, 3, 15, 0);
        lit("set1 hit3", 3, 1, 1);
        miss(1, 15);
        lit("set1 miss after hit", 0, 1, 0);
        miss(7, 15);
        lit("set7 first", 0, 1, 0);
        miss(9, 15);
        lit("set9 first", 0, 1, 0);
        miss(7, 15);
        lit("set7 second", 2, 1, 0);
        cyc(0, 1, 7, 0, 0, 15, 1);
        lit("flush drops req", 2, 0, 0);
        miss(7, 15);
        lit("set7 after flush", 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 15), 0);
        cyc(1, 1, 3, 1, 3, 15, 0);
        lit("mid-stream reset", 0, 0, 0);
        miss(3, 15);
        lit("set3 after reset", 0, 1, 0);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5),
                $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 15,
                $urandom_range(0, 39) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
